tm_tb_fill: RTL and testbench
=============================

# tm_tb_fill

Token-bucket fill engine for the first-level traffic manager scheduler. On a programmable period it sweeps queues 0..last_queue and, for each queue, performs a read-modify-write of the CIR and EIR shaping profiles through the application ports of the first-level scheduler memory block. Each bucket is credited by its fill rate and clamped at its burst size. The packet-path debit logic in the first-level scheduler uses fill_qid/fill_active to avoid racing the sweep.

## Interface
- QUEUE_NBITS, `FIRST_LVL_QUEUE_ID_NBITS: queue index width.
- TOKEN_NBITS, 20: signed token count width; also the width of the burst field.
- RATE_NBITS, 12: unsigned fill-rate width.
- Profile word layout, width PROF_NBITS = RATE_NBITS+2*TOKEN_NBITS (must equal `SHAPING_PROFILE_NBITS`): {rate, burst, tokens}, with tokens in the LSBs.

Ports:
- clk  in  1  single clock.
- `RESET_SIG (resetn)  in  1  asynchronous, active-low reset.
- fill_en  in  1  enables the period counter.
- fill_period  in  16  cycles between sweep starts; 0 means disabled.
- last_queue  in  QUEUE_NBITS  highest queue index swept.
- overrun_clr  in  1  clears sweep_overrun.
- shaping_profile_cir_rd / _raddr  out  1 / QUEUE_NBITS  read request.
- shaping_profile_cir_ack / _rdata  in  1 / PROF_NBITS  read return; rdata is valid with ack.
- shaping_profile_cir_wr / _waddr / _wdata  out  1 / QUEUE_NBITS / PROF_NBITS  write-back.
- shaping_profile_eir_*: the same set of ports, for EIR.
- fill_active  out  1  high while a sweep is in progress.
- fill_qid  out  QUEUE_NBITS  queue currently being processed.
- sweep_done  out  1  one-cycle pulse.
- sweep_overrun  out  1  sticky flag.

## Operation
- States: IDLE, RD, WAIT, CALC, WR.
- **Period counter**
  - Counts while fill_en=1 and fill_period≠0.
  - At count fill_period-1 it emits a tick and reloads to 0.
  - While disabled, the counter is held at 0.
- **Starting a sweep**
  - A tick in IDLE sets qid=0 and moves to RD on the next cycle.
  - A tick outside IDLE sets pending=1 and sweep_overrun=1.
  - Further ticks while pending=1 are absorbed; only one start is held.
- **RD:** assert cir_rd and eir_rd for one cycle with raddr=qid, then go to WAIT.
- **WAIT**
  - Capture each ack/rdata independently; acks may arrive on different cycles.
  - Leave WAIT the cycle after both are captured, and go to CALC.
  - Acks outside WAIT are ignored.
- **CALC**
  - Per profile: sum = sign-extended tokens + zero-extended rate, computed in TOKEN_NBITS+1 bits.
  - new_tokens = min(sum, burst).
  - If tokens > burst on read (reconfiguration), new_tokens = burst.
  - rate=0 leaves tokens unchanged except for the clamp.
  - Negative tokens are credited normally with no floor.
  - rate and burst are written back unchanged.
- **WR**
  - Assert cir_wr and eir_wr for one cycle, waddr=qid.
  - If qid==last_queue: pulse sweep_done. Then go to RD with qid=0 if pending (clearing pending), otherwise go to IDLE.
  - Else: qid+1 and go to RD.
- **fill_en deassert mid-sweep:** the current sweep completes, pending is cleared, and the counter is held.
- **last_queue:** sampled at sweep start; changes take effect on the next sweep.
- **overrun_clr:** clears sweep_overrun. If a tick causes an overrun in the same cycle, the set wins.
- **Reset mid-sweep:** aborts with no write issued; the memory keeps the last written values.

## Timing
- Reset values: all outputs 0, state IDLE, qid/counter/pending 0.
- fill_active=1 in RD/WAIT/CALC/WR.
- fill_qid = qid while active, 0 otherwise.
- Per-queue latency = 3 + read latency cycles. With ack one cycle after rd: RD, WAIT (ack captured), CALC, WR = 4 cycles.
- Back-to-back queues: the next RD follows WR immediately.
- A full sweep of N queues with 1-cycle ack takes 4N cycles. A fill_period ≤ 4N guarantees overrun.
- Write data and address are stable only while wr=1. rd and wr are never asserted in the same cycle.

## Test plan
- **Basic fill:** last_queue=3, fill_period=100; CIR q2 = {rate=5, burst=1000, tokens=10} -> after one sweep, q2 CIR write is {5, 1000, 15}; sweep_done pulses once per 100 cycles.
- **Clamp and negative:** tokens=998, rate=5, burst=1000 -> written 1000. tokens=-50 (two's complement), rate=20 -> written -30. tokens=1200, burst=1000, rate=0 -> written 1000.
- **Skewed acks:** CIR ack 1 cycle after rd, EIR ack 6 cycles after rd, EIR rdata corrupted outside the ack cycle -> both writes in the same cycle, 8 cycles after rd, with correct data.
- **Overrun:** last_queue=15, fill_period=20 -> sweep_overrun=1. Exactly one back-to-back sweep restart (RD qid 0 in the cycle after the last WR). overrun_clr then drops the flag.
- **Disable and reset:** fill_en dropped at qid=5 of 8 -> queues 5..7 complete, sweep_done pulses, then no further rd. Reset asserted in WAIT -> all outputs 0 immediately, and no wr follows after reset release until the next tick.

Source files
------------

// File: rtl/tm_tb_fill_if.sv
// tm_tb_fill_if: application read/write port of one shaping-profile memory
interface tm_tb_fill_if #(
    parameter int QUEUE_NBITS = 6,
    parameter int PROF_NBITS  = 52
);
    logic                   rd;
    logic [QUEUE_NBITS-1:0] raddr;
    logic                   ack;
    logic [PROF_NBITS-1:0]  rdata;
    logic                   wr;
    logic [QUEUE_NBITS-1:0] waddr;
    logic [PROF_NBITS-1:0]  wdata;
    modport master (output rd, raddr, wr, waddr, wdata, input ack, rdata);
    modport slave  (input rd, raddr, wr, waddr, wdata, output ack, rdata);
endinterface

// File: rtl/tm_tb_fill.sv
// tm_tb_fill: periodic token-bucket fill sweep over CIR/EIR shaping profiles
module tm_tb_fill #(
    parameter int QUEUE_NBITS = 6,
    parameter int TOKEN_NBITS = 20,
    parameter int RATE_NBITS  = 12,
    parameter int PROF_NBITS  = RATE_NBITS + 2 * TOKEN_NBITS
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   fill_en,
    input  logic [15:0]            fill_period,
    input  logic [QUEUE_NBITS-1:0] last_queue,
    input  logic                   overrun_clr,
    tm_tb_fill_if.master           shaping_profile_cir,
    tm_tb_fill_if.master           shaping_profile_eir,
    output logic                   fill_active,
    output logic [QUEUE_NBITS-1:0] fill_qid,
    output logic                   sweep_done,
    output logic                   sweep_overrun
);
    typedef enum logic [2:0] {IDLE, RD, WAIT, CALC, WR} state_t;

    state_t                 state, state_d;
    logic [15:0]            cnt;
    logic [QUEUE_NBITS-1:0] qid, lastq;
    logic                   pending, cir_got, eir_got;
    logic [PROF_NBITS-1:0]  cir_q, eir_q;
    logic                   period_on, tick, last, restart, both, start;

    // credit one bucket by its rate and clamp at burst; rate/burst pass through
    function automatic logic [PROF_NBITS-1:0] fill(input logic [PROF_NBITS-1:0] w);
        logic signed [TOKEN_NBITS:0] tok, burst, sum;
        tok   = {w[TOKEN_NBITS-1], w[TOKEN_NBITS-1:0]};
        burst = {1'b0, w[2*TOKEN_NBITS-1 -: TOKEN_NBITS]};
        sum   = tok + {{(TOKEN_NBITS+1-RATE_NBITS){1'b0}}, w[PROF_NBITS-1 -: RATE_NBITS]};
        return {w[PROF_NBITS-1:TOKEN_NBITS],
                (tok > burst || sum > burst) ? burst[TOKEN_NBITS-1:0] : sum[TOKEN_NBITS-1:0]};
    endfunction

    assign period_on = fill_en && fill_period != 16'd0;
    assign tick      = period_on && cnt >= fill_period - 16'd1;
    assign last      = qid == lastq;
    assign restart   = (fill_en && pending) || tick;
    assign both      = (cir_got || shaping_profile_cir.ack) && (eir_got || shaping_profile_eir.ack);
    assign start     = (state == IDLE && tick) || (state == WR && last && restart);

    // next-state: one queue is RD, WAIT (until both acks), CALC, WR
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = tick ? RD : IDLE;
            RD:      state_d = WAIT;
            WAIT:    state_d = both ? CALC : WAIT;
            CALC:    state_d = WR;
            WR:      state_d = (!last || restart) ? RD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state, period counter, sweep bookkeeping and profile datapath
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            cnt           <= '0;
            qid           <= '0;
            lastq         <= '0;
            pending       <= 1'b0;
            sweep_overrun <= 1'b0;
            cir_got       <= 1'b0;
            eir_got       <= 1'b0;
            cir_q         <= '0;
            eir_q         <= '0;
        end else begin
            state         <= state_d;
            cnt           <= (!period_on || tick) ? 16'd0 : cnt + 16'd1;
            qid           <= (state == WR) ? (last ? '0 : qid + QUEUE_NBITS'(1)) : qid;
            lastq         <= start ? last_queue : lastq;
            pending       <= (!fill_en || (state == WR && last)) ? 1'b0 :
                             (tick && state != IDLE) ? 1'b1 : pending;
            sweep_overrun <= (tick && state != IDLE) ? 1'b1 : overrun_clr ? 1'b0 : sweep_overrun;
            cir_got       <= (state == RD) ? 1'b0 : (state == WAIT && shaping_profile_cir.ack) ? 1'b1 : cir_got;
            eir_got       <= (state == RD) ? 1'b0 : (state == WAIT && shaping_profile_eir.ack) ? 1'b1 : eir_got;
            cir_q         <= (state == WAIT && shaping_profile_cir.ack && !cir_got) ? shaping_profile_cir.rdata :
                             (state == CALC) ? fill(cir_q) : cir_q;
            eir_q         <= (state == WAIT && shaping_profile_eir.ack && !eir_got) ? shaping_profile_eir.rdata :
                             (state == CALC) ? fill(eir_q) : eir_q;
        end
    end

    assign fill_active               = state != IDLE;
    assign fill_qid                  = fill_active ? qid : '0;
    assign sweep_done                = state == WR && last;
    assign shaping_profile_cir.rd    = state == RD;
    assign shaping_profile_eir.rd    = state == RD;
    assign shaping_profile_cir.raddr = state == RD ? qid : '0;
    assign shaping_profile_eir.raddr = state == RD ? qid : '0;
    assign shaping_profile_cir.wr    = state == WR;
    assign shaping_profile_eir.wr    = state == WR;
    assign shaping_profile_cir.waddr = state == WR ? qid : '0;
    assign shaping_profile_eir.waddr = state == WR ? qid : '0;
    assign shaping_profile_cir.wdata = state == WR ? cir_q : '0;
    assign shaping_profile_eir.wdata = state == WR ? eir_q : '0;
endmodule

// File: tb/tb_tm_tb_fill.sv
// tb_tm_tb_fill: directed and randomized checks of the token-bucket fill sweep
module tb_tm_tb_fill;
    localparam int QN = 6, TN = 20, RN = 12, PN = RN + 2 * TN;

    logic           clk = 1'b0, resetn = 1'b0, fill_en = 1'b0, overrun_clr = 1'b0;
    logic [15:0]    fill_period = '0;
    logic [QN-1:0]  last_queue = '0;
    logic           fill_active, sweep_done, sweep_overrun;
    logic [QN-1:0]  fill_qid;
    logic [38:0]    outs;
    logic [63:0]    noise_c, noise_e;
    logic [PN-1:0]  mem_cir [64];
    logic [PN-1:0]  mem_eir [64];
    logic [QN-1:0]  addr_c = '0, addr_e = '0;
    int             errors = 0, checks = 0, cyc = 0;
    int             dly_c = 1, dly_e = 1, cd_c = 0, cd_e = 0, rd_cnt = 0, wr_cnt = 0;
    int             wr_q [$];

    tm_tb_fill_if #(.QUEUE_NBITS(QN), .PROF_NBITS(PN)) cir_if ();
    tm_tb_fill_if #(.QUEUE_NBITS(QN), .PROF_NBITS(PN)) eir_if ();

    tm_tb_fill #(.QUEUE_NBITS(QN), .TOKEN_NBITS(TN), .RATE_NBITS(RN)) dut (
        .clk                 (clk),
        .resetn              (resetn),
        .fill_en             (fill_en),
        .fill_period         (fill_period),
        .last_queue          (last_queue),
        .overrun_clr         (overrun_clr),
        .shaping_profile_cir (cir_if.master),
        .shaping_profile_eir (eir_if.master),
        .fill_active         (fill_active),
        .fill_qid            (fill_qid),
        .sweep_done          (sweep_done),
        .sweep_overrun       (sweep_overrun)
    );

    assign outs = {cir_if.rd, cir_if.wr, eir_if.rd, eir_if.wr, fill_active, sweep_done, sweep_overrun,
                   fill_qid, cir_if.raddr, cir_if.waddr, eir_if.raddr, eir_if.waddr,
                   |cir_if.wdata, |eir_if.wdata};

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    function automatic logic [PN-1:0] prof(input int rate, input int burst, input int tok);
        logic [31:0] r, b, t;
        r = rate; b = burst; t = tok;
        return {r[RN-1:0], b[TN-1:0], t[TN-1:0]};
    endfunction

    function automatic logic [PN-1:0] rand_prof();
        return prof(int'($urandom_range(0, 4095)), int'($urandom_range(0, 500000)),
                    int'($urandom_range(0, 1048575)) - 524288);
    endfunction

    // reference bucket: credit by rate, never above burst, no floor for debt
    function automatic logic [PN-1:0] fill_ref(input logic [PN-1:0] w);
        int rate, burst, tok, n;
        rate  = int'(w[PN-1 -: RN]);
        burst = int'(w[2*TN-1 -: TN]);
        tok   = int'($signed(w[TN-1:0]));
        n = (tok > burst) ? burst : (tok + rate > burst) ? burst : tok + rate;
        return {w[PN-1:TN], n[TN-1:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ev(input string tag, input bit on_done, input int max, output int at);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < max && !hit; i++) begin
            step();
            hit = on_done ? sweep_done : cir_if.rd;
        end
        at = cyc;
        chk({tag, "_timeout"}, 64'(hit), 64'(1));
    endtask

    task automatic rand_mem(input int n);
        for (int q = 0; q < n; q++) begin
            mem_cir[q] = rand_prof();
            mem_eir[q] = rand_prof();
        end
    endtask

    // CIR memory: delayed ack, garbage rdata outside ack, checks every write-back
    initial begin
        cir_if.ack = 1'b0; cir_if.rdata = '0;
        forever begin
            @(negedge clk);
            noise_c = {$urandom, $urandom};
            cir_if.ack = 1'b0; cir_if.rdata = noise_c[PN-1:0];
            if (cd_c > 0) begin
                cd_c--;
                if (cd_c == 0) begin cir_if.ack = 1'b1; cir_if.rdata = mem_cir[addr_c]; end
            end
            if (cir_if.rd) begin cd_c = dly_c; addr_c = cir_if.raddr; rd_cnt++; end
            if (cir_if.wr) begin
                chk("cir_wdata", 64'(cir_if.wdata), 64'(fill_ref(mem_cir[cir_if.waddr])));
                chk("wr_pair", 64'({eir_if.wr, eir_if.waddr, cir_if.rd, eir_if.rd}),
                    64'({1'b1, cir_if.waddr, 2'b00}));
                mem_cir[cir_if.waddr] = cir_if.wdata;
                wr_cnt++;
                wr_q.push_back(int'(cir_if.waddr));
            end
        end
    end

    // EIR memory: same behaviour with its own ack delay
    initial begin
        eir_if.ack = 1'b0; eir_if.rdata = '0;
        forever begin
            @(negedge clk);
            noise_e = {$urandom, $urandom};
            eir_if.ack = 1'b0; eir_if.rdata = noise_e[PN-1:0];
            if (cd_e > 0) begin
                cd_e--;
                if (cd_e == 0) begin eir_if.ack = 1'b1; eir_if.rdata = mem_eir[addr_e]; end
            end
            if (eir_if.rd) begin cd_e = dly_e; addr_e = eir_if.raddr; end
            if (eir_if.wr) begin
                chk("eir_wdata", 64'(eir_if.wdata), 64'(fill_ref(mem_eir[eir_if.waddr])));
                mem_eir[eir_if.waddr] = eir_if.wdata;
            end
        end
    end

    initial begin
        int t0, t1, t2, r0, w0;
        bit hit;
        rand_mem(64);
        repeat (3) step();
        chk("reset_outs", 64'(outs), 64'(0));
        resetn = 1'b1;
        step();

        // basic fill
        rand_mem(16);
        mem_cir[2] = prof(5, 1000, 10);
        wr_q.delete();
        last_queue = 6'd3; fill_period = 16'd100; fill_en = 1'b1;
        wait_ev("b_rd", 1'b0, 200, t0);
        wait_ev("b_done", 1'b1, 50, t1);
        chk("b_len", 64'(t1 - t0), 64'(15));
        step();
        chk("b_q2", 64'(mem_cir[2]), 64'(prof(5, 1000, 15)));
        chk("b_nwr", 64'(wr_q.size()), 64'(4));
        for (int i = 0; i < 4; i++) chk("b_addr", 64'(wr_q[i]), 64'(i));
        chk("b_ovr", 64'(sweep_overrun), 64'(0));
        wait_ev("b_done2", 1'b1, 200, t2);
        chk("b_period", 64'(t2 - t1), 64'(100));
        step();
        chk("b_q2_2", 64'(mem_cir[2]), 64'(prof(5, 1000, 20)));
        fill_en = 1'b0;
        repeat (5) step();

        // clamp, negative, reconfigured burst
        rand_mem(3);
        mem_cir[0] = prof(5, 1000, 998);
        mem_cir[1] = prof(20, 1000, -50);
        mem_cir[2] = prof(0, 1000, 1200);
        last_queue = 6'd2; fill_period = 16'd30; fill_en = 1'b1;
        wait_ev("c_done", 1'b1, 100, t0);
        fill_en = 1'b0;
        step();
        chk("c_clamp", 64'(mem_cir[0]), 64'(prof(5, 1000, 1000)));
        chk("c_neg", 64'(mem_cir[1]), 64'(prof(20, 1000, -30)));
        chk("c_reconf", 64'(mem_cir[2]), 64'(prof(0, 1000, 1000)));
        repeat (5) step();

        // skewed acks
        dly_e = 6;
        mem_cir[0] = prof(7, 500, 100);
        mem_eir[0] = prof(3, 50, 49);
        last_queue = 6'd0; fill_period = 16'd50; fill_en = 1'b1;
        wait_ev("s_rd", 1'b0, 100, t0);
        wait_ev("s_done", 1'b1, 20, t1);
        fill_en = 1'b0;
        chk("s_lat", 64'(t1 - t0), 64'(8));
        step();
        chk("s_cir", 64'(mem_cir[0]), 64'(prof(7, 500, 107)));
        chk("s_eir", 64'(mem_eir[0]), 64'(prof(3, 50, 50)));
        dly_e = 1;
        repeat (5) step();

        // overrun and single back-to-back restart
        rand_mem(16);
        last_queue = 6'd15; fill_period = 16'd20; fill_en = 1'b1;
        wait_ev("o_rd", 1'b0, 100, t0);
        wait_ev("o_done", 1'b1, 100, t1);
        chk("o_len", 64'(t1 - t0), 64'(63));
        chk("o_flag", 64'(sweep_overrun), 64'(1));
        step();
        chk("o_restart", 64'({cir_if.rd, cir_if.raddr, fill_active}), 64'({1'b1, 6'd0, 1'b1}));
        fill_en = 1'b0;
        wait_ev("o_done2", 1'b1, 100, t2);
        chk("o_len2", 64'(t2 - t1), 64'(64));
        r0 = rd_cnt;
        repeat (100) step();
        chk("o_quiet", 64'(rd_cnt - r0), 64'(0));
        chk("o_sticky", 64'(sweep_overrun), 64'(1));
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        chk("o_clr", 64'(sweep_overrun), 64'(0));

        // disable mid-sweep at queue 5 of 8
        rand_mem(8);
        last_queue = 6'd7; fill_period = 16'd60; fill_en = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            step();
            hit = cir_if.rd && fill_qid == 6'd5;
        end
        chk("d_reach", 64'(hit), 64'(1));
        fill_en = 1'b0;
        wr_q.delete();
        w0 = wr_cnt;
        wait_ev("d_done", 1'b1, 50, t0);
        step();
        chk("d_nwr", 64'(wr_cnt - w0), 64'(3));
        chk("d_first", 64'(wr_q[0]), 64'(5));
        chk("d_last", 64'(wr_q[2]), 64'(7));
        r0 = rd_cnt;
        repeat (150) step();
        chk("d_quiet", 64'(rd_cnt - r0), 64'(0));

        // reset while waiting for acks
        dly_e = 6;
        rand_mem(4);
        last_queue = 6'd3; fill_period = 16'd40; fill_en = 1'b1;
        wait_ev("r_rd", 1'b0, 100, t0);
        step();
        chk("r_active", 64'(fill_active), 64'(1));
        resetn = 1'b0;
        #1;
        chk("r_outs", 64'(outs), 64'(0));
        repeat (3) step();
        resetn = 1'b1;
        w0 = wr_cnt;
        repeat (30) step();
        chk("r_nowr", 64'(wr_cnt - w0), 64'(0));
        wait_ev("r_resume", 1'b1, 200, t1);
        fill_en = 1'b0;
        dly_e = 1;
        repeat (10) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
